// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the EX stage and the multi-cycle M-extension unit.
// The master (pipeline side) issues requests; the slave (muldiv_seq) answers.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, x, y, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, x, y, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle unit: shift-add multiply and restoring divide, one bit
// per clock. Operands are reduced to magnitudes when accepted and the sign is
// restored on the last iteration edge. Divide-by-zero and signed overflow are
// answered directly from IDLE without entering CALC.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [0:0] {IDLE, CALC} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;        // final result must be negated
    logic [XLEN-1:0]   opb_q, opb_d;        // multiplicand / divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;        // {hi, lo}: product or {remainder, quotient}
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] fin_prod;
    logic [XLEN-1:0]   fin;

    // Start decode
    logic x_signed, y_signed, x_neg, y_neg;
    logic div_zero, div_ovf;

    // Two's-complement sign restore, single width
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // Two's-complement sign restore, full product width
    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign bus.busy   = (state_q == CALC);
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // One multiply or divide iteration plus the sign-corrected final value
    always_comb begin
        addend  = acc_q[0] ? opb_q : '0;
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        trial   = rem_sh - {1'b0, opb_q};
        step    = {mul_sum, acc_q[XLEN-1:1]};
        if (op_q[2]) begin
            if (!trial[XLEN]) begin
                step = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end
        fin_prod = neg_2x(step, neg_q);
        case (op_q)
            3'b000:                 fin = fin_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin = fin_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin = neg_x(step[XLEN-1:0], neg_q);
            default:                fin = neg_x(step[2*XLEN-1:XLEN], neg_q);
        endcase
    end

    // Operand signedness and IDLE-resolved special cases
    always_comb begin
        x_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                   (bus.op == 3'b100) || (bus.op == 3'b110);
        y_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        x_neg    = x_signed && bus.x[XLEN-1];
        y_neg    = y_signed && bus.y[XLEN-1];
        div_zero = bus.op[2] && (bus.y == '0);
        div_ovf  = bus.op[2] && !bus.op[0] && (&bus.y) &&
                   (bus.x == {1'b1, {(XLEN-1){1'b0}}});
    end

    // Next-state and control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.kill) begin
                    if (div_zero) begin
                        result_d = bus.op[1] ? bus.x : '1;
                        done_d   = 1'b1;
                    end else if (div_ovf) begin
                        result_d = bus.op[1] ? '0 : bus.x;
                        done_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = '0;
                        op_d    = bus.op;
                        // remainder follows the dividend, everything else the xor
                        neg_d   = (bus.op[2] && bus.op[1]) ? x_neg : (x_neg ^ y_neg);
                        acc_d   = {{XLEN{1'b0}}, neg_x(bus.x, x_neg)};
                        opb_d   = neg_x(bus.y, y_neg);
                    end
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d  = IDLE;
                        result_d = fin;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against a plain-arithmetic
// RV32M reference model.
module tb_muldiv_seq;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(XLEN)) bus ();
    muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        logic signed [63:0] xs, ys;
        logic [63:0] xu, yu, p;
        logic [31:0] q;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        xu = {32'b0, x};
        yu = {32'b0, y};
        case (op)
            3'd0: begin p = xu * yu; return p[31:0]; end
            3'd1: begin p = xs * ys; return p[63:32]; end
            3'd2: begin p = xs * $signed(yu); return p[63:32]; end
            3'd3: begin p = xu * yu; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN && y == 32'hFFFF_FFFF) return x;
                q = $signed(x) / $signed(y);
                return q;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN && y == 32'hFFFF_FFFF) return 32'h0;
                q = $signed(x) % $signed(y);
                return q;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Issue one op from the current cycle (+1 after an edge) and follow it to done,
    // scrambling inputs and pulsing start while the unit is busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_r, input string tag);
        bit special;
        int lat, busy_n;
        special = op[2] && (y == 0 || (!op[0] && x == MIN && y == 32'hFFFF_FFFF));
        bus.start = 1'b1; bus.op = op; bus.x = x; bus.y = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0; busy_n = 0;
        if (bus.busy) busy_n++;
        while (!bus.done && lat < 3 * XLEN) begin
            bus.x  = $urandom;
            bus.y  = $urandom;
            bus.op = 3'($urandom);
            bus.start = (lat == 4);
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busy_n++;
        end
        bus.start = 1'b0;
        chk({tag, " latency"}, lat, special ? 0 : XLEN);
        chk({tag, " busy_cycles"}, busy_n, special ? 0 : XLEN);
        chk({tag, " result"}, bus.result, exp_r);
        last_res = exp_r;
    endtask

    logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_x  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd5, 32'h1234, MIN, MIN};
    logic [31:0] d_y  [12] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd2, 32'd2, 32'd2,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_e  [12] = '{32'h0000_002A, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h1,
                               32'hFFFF_FFFF, 32'h0000_1234, MIN, 32'h0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        logic [31:0] rx, ry;
        logic [2:0]  rop;
        rst = 1'b1; bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset result", bus.result, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table, issued back-to-back
        for (int i = 0; i < 12; i++)
            run_op(d_op[i], d_x[i], d_y[i], d_e[i], $sformatf("dir%0d", i));
        run_op(3'd5, MIN, 32'hFFFF_FFFF, 32'h0, "divu_nospecial");
        run_op(3'd7, MIN, 32'hFFFF_FFFF, MIN, "remu_nospecial");

        // Done is a single pulse and result holds while idle
        @(posedge clk); #1;
        chk("done pulse", bus.done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle hold", bus.result, last_res);

        // Kill mid-calculation, then restart
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "prekill");
        bus.start = 1'b1; bus.op = 3'd0; bus.x = 32'd3; bus.y = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        chk("kill busy", bus.busy, 0);
        chk("kill done", bus.done, 0);
        chk("kill result", bus.result, last_res);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        chk("kill no_done", done_seen, 0);
        run_op(3'd5, 32'd100, 32'd7, 32'h0000_000E, "divu_after_kill");

        // Kill together with start in IDLE blocks the request
        bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'd4; bus.x = 32'd9; bus.y = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        chk("killstart busy", bus.busy, 0);
        chk("killstart done", bus.done, 0);
        chk("killstart result", bus.result, last_res);

        // Randomized ops with corner-biased operands
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            case ($urandom_range(0, 4))
                0: rx = MIN;
                1: rx = 32'hFFFF_FFFF;
                2: rx = $urandom_range(0, 20);
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: ry = 32'h0;
                1: ry = 32'hFFFF_FFFF;
                2: ry = $urandom_range(1, 20);
                default: ry = $urandom;
            endcase
            run_op(rop, rx, ry, ref_result(rop, rx, ry), $sformatf("rnd%0d", i));
        end

        // Reset mid-calculation clears everything
        bus.start = 1'b1; bus.op = 3'd3; bus.x = 32'hDEAD_BEEF; bus.y = 32'h1234_5678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", bus.busy, 0);
        chk("midrst done", bus.done, 0);
        chk("midrst result", bus.result, 0);
        run_op(3'd1, 32'h8000_0000, 32'h0000_0003, ref_result(3'd1, MIN, 32'd3), "after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
